// File: rtl/irq_ctrl_pkg.sv
// Shared types and constants for the irq_ctrl interrupt controller.
package irq_ctrl_pkg;

  localparam int unsigned N_CH_DEF        = 4;
  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned ID_W_DEF        = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam logic [6:0] DBG_PENDING = 7'd0;
  localparam logic [6:0] DBG_MASK    = 7'd1;
  localparam logic [6:0] DBG_STATUS  = 7'd2;
  localparam logic [6:0] DBG_ACKS    = 7'd3;
  localparam logic [6:0] DBG_LOST    = 7'd4;

  function automatic logic [31:0] count_ones(input logic [31:0] v);
    logic [31:0] n;
    n = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      n = n + {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/irq_ctrl_sync_edge.sv
// One interrupt channel: SYNC_STAGES-deep synchroniser followed by a rising-edge detector.
module irq_sync_edge
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync[0] <= d;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync[i] <= sync[i-1];
      end
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign rise = sync[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/irq_ctrl.sv
// Multi-channel fixed-priority interrupt controller with ack/eret handshake.
// Optional debug read port enabled by IRQ_CTRL_DEBUG_EN.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned    N_CH        = N_CH_DEF,
  parameter int unsigned    SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned    ID_W        = ID_W_DEF,
  parameter logic [N_CH-1:0] MASK_RST   = '1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] irq_in,
  input  logic            mask_we,
  input  logic [N_CH-1:0] mask_wdata,
  input  logic            ack,
  input  logic            eret,
  output logic            irq_req,
  output logic [ID_W-1:0] irq_id,
  output logic [N_CH-1:0] pending,
  output logic            in_service
`ifdef IRQ_CTRL_DEBUG_EN
  ,
  input  logic [6:0]      debug_addr,
  output logic [31:0]     debug_data
`endif
);

  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] mask;
  logic [N_CH-1:0] cand;
  logic [N_CH-1:0] clr;
  logic [ID_W-1:0] sel;
  logic            valid;

  state_t          state, state_nxt;
  logic            req_nxt, svc_nxt, take;
  logic [ID_W-1:0] id_nxt;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk),
      .rst  (rst),
      .d    (irq_in[g]),
      .rise (rise[g])
    );
  end

  assign cand = pending & mask;

  always_comb begin
    sel   = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (!valid && cand[i]) begin
        sel   = ID_W'(i);
        valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    req_nxt   = irq_req;
    id_nxt    = irq_id;
    svc_nxt   = in_service;
    take      = 1'b0;
    unique case (state)
      IDLE: begin
        if (valid) begin
          state_nxt = REQ;
          id_nxt    = sel;
          req_nxt   = 1'b1;
        end
      end
      REQ: begin
        if (ack) begin
          take      = 1'b1;
          req_nxt   = 1'b0;
          svc_nxt   = 1'b1;
          state_nxt = SERVICE;
        end
      end
      SERVICE: begin
        if (eret) begin
          svc_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    clr = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      clr[i] = take && (irq_id == ID_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      irq_req    <= 1'b0;
      irq_id     <= '0;
      in_service <= 1'b0;
      pending    <= '0;
      mask       <= MASK_RST;
    end else begin
      state      <= state_nxt;
      irq_req    <= req_nxt;
      irq_id     <= id_nxt;
      in_service <= svc_nxt;
      // a fresh edge outranks the ack clear on the same channel
      pending    <= (pending & ~clr) | rise;
      if (mask_we) begin
        mask <= mask_wdata;
      end
    end
  end

`ifdef IRQ_CTRL_DEBUG_EN
  logic [N_CH-1:0] lost;
  logic [31:0]     ack_cnt;
  logic [31:0]     lost_cnt;

  // an edge is only lost when the channel stays pending without being consumed
  assign lost = rise & pending & ~clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_cnt  <= '0;
      lost_cnt <= '0;
    end else begin
      if (take) begin
        ack_cnt <= ack_cnt + 32'd1;
      end
      lost_cnt <= lost_cnt + count_ones(32'(lost));
    end
  end

  always_comb begin
    debug_data = '0;
    case (debug_addr)
      DBG_PENDING: debug_data = 32'(pending);
      DBG_MASK:    debug_data = 32'(mask);
      DBG_STATUS:  debug_data = 32'({state, in_service, irq_id});
      DBG_ACKS:    debug_data = ack_cnt;
      DBG_LOST:    debug_data = lost_cnt;
      default:     debug_data = '0;
    endcase
  end
`endif

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl (4 channels, 2 sync stages).
module tb_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] irq_in;
  logic       mask_we;
  logic [3:0] mask_wdata;
  logic       ack;
  logic       eret;
  logic       irq_req;
  logic [1:0] irq_id;
  logic [3:0] pending;
  logic       in_service;
`ifdef IRQ_CTRL_DEBUG_EN
  logic [6:0]  debug_addr;
  logic [31:0] debug_data;
`endif

  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;

  irq_ctrl #(
    .N_CH        (4),
    .SYNC_STAGES (2),
    .ID_W        (2),
    .MASK_RST    (4'b1111)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .irq_in     (irq_in),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .ack        (ack),
    .eret       (eret),
    .irq_req    (irq_req),
    .irq_id     (irq_id),
    .pending    (pending),
    .in_service (in_service)
`ifdef IRQ_CTRL_DEBUG_EN
    ,
    .debug_addr (debug_addr),
    .debug_data (debug_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic [3:0] irq;
    logic       ack;
    logic       eret;
    logic       e_req;
    logic [1:0] e_id;
    logic [3:0] e_pend;
    logic       e_svc;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic e_req, input logic [1:0] e_id,
                            input logic [3:0] e_pend, input logic e_svc);
    check({tag, " irq_req"},    32'(irq_req),    32'(e_req));
    check({tag, " irq_id"},     32'(irq_id),     32'(e_id));
    check({tag, " pending"},    32'(pending),    32'(e_pend));
    check({tag, " in_service"}, 32'(in_service), 32'(e_svc));
  endtask

`ifdef IRQ_CTRL_DEBUG_EN
  task automatic serve(input int unsigned ch, input bit lose);
    irq_in[ch] = 1'b1; tick();
    irq_in = '0; tick(); tick(); tick();
    check("dbg req", 32'(irq_req), 32'd1);
    check("dbg id", 32'(irq_id), ch);
    if (lose) begin
      irq_in[ch] = 1'b1; tick();
      irq_in = '0; tick(); tick();
    end
    ack = 1'b1; tick(); ack = 1'b0;
    eret = 1'b1; tick(); eret = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1; irq_in = '0; mask_we = 1'b0; mask_wdata = '0; ack = 1'b0; eret = 1'b0;
`ifdef IRQ_CTRL_DEBUG_EN
    debug_addr = '0;
`endif

    // rst, irq, ack, eret | req, id, pend, svc  (values after the edge)
    for (int i = 0; i < 5; i++) vecs.push_back('{1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0});
    vecs.push_back('{1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0});
    vecs.push_back('{1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0});
    vecs.push_back('{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0001, 1'b0});
    vecs.push_back('{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b0});
    vecs.push_back('{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1});
    vecs.push_back('{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0});
    vecs.push_back('{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0});
    vecs.push_back('{1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0});
    vecs.push_back('{1'b0, 4'b0110, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0});
    vecs.push_back('{1'b0, 4'b0110, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0100, 1'b0});
    vecs.push_back('{1'b0, 4'b0110, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0110, 1'b0});
    vecs.push_back('{1'b0, 4'b0110, 1'b0, 1'b1, 1'b1, 2'd2, 4'b0110, 1'b0});
    vecs.push_back('{1'b0, 4'b0110, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0010, 1'b1});
    vecs.push_back('{1'b0, 4'b0110, 1'b0, 1'b1, 1'b0, 2'd2, 4'b0010, 1'b0});
    vecs.push_back('{1'b0, 4'b0110, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b0});
    vecs.push_back('{1'b0, 4'b0110, 1'b1, 1'b0, 1'b0, 2'd1, 4'b0000, 1'b1});
    vecs.push_back('{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd1, 4'b0000, 1'b0});
    vecs.push_back('{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd1, 4'b0000, 1'b0});

    foreach (vecs[i]) begin
      rst = vecs[i].rst; irq_in = vecs[i].irq; ack = vecs[i].ack; eret = vecs[i].eret;
      tick();
      check_outs($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_id, vecs[i].e_pend, vecs[i].e_svc);
    end
    rst = 1'b0; irq_in = '0; ack = 1'b0; eret = 1'b0;

    // masked channel latches pending but is never selected
    mask_we = 1'b1; mask_wdata = 4'b1110; tick(); mask_we = 1'b0;
    irq_in = 4'b0001; tick(); tick(); irq_in = '0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("mask hold req", 32'(irq_req), 32'd0);
    end
    check("mask pending", 32'(pending), 32'h1);
    mask_we = 1'b1; mask_wdata = 4'b1111; tick(); mask_we = 1'b0;
    check("unmask edge1 req", 32'(irq_req), 32'd0);
    tick();
    check_outs("unmask edge2", 1'b1, 2'd0, 4'b0001, 1'b0);
    ack = 1'b1; tick(); ack = 1'b0;
    eret = 1'b1; tick(); eret = 1'b0;

    // new edge on channel 3 in the ack cycle keeps it pending
    irq_in = 4'b1000; tick(); irq_in = '0; tick(); tick(); tick();
    check_outs("sw req", 1'b1, 2'd3, 4'b1000, 1'b0);
    irq_in = 4'b1000; tick(); irq_in = '0; tick();
    ack = 1'b1; tick(); ack = 1'b0;
    check_outs("sw ack", 1'b0, 2'd3, 4'b1000, 1'b1);
    eret = 1'b1; tick(); eret = 1'b0;
    check("sw eret req", 32'(irq_req), 32'd0);
    tick();
    check_outs("sw rereq", 1'b1, 2'd3, 4'b1000, 1'b0);
    // masking the requested channel does not withdraw the request
    mask_we = 1'b1; mask_wdata = 4'b0111; tick(); mask_we = 1'b0;
    check_outs("mask in req", 1'b1, 2'd3, 4'b1000, 1'b0);
    ack = 1'b1; tick(); ack = 1'b0;
    eret = 1'b1; tick(); eret = 1'b0;
    mask_we = 1'b1; mask_wdata = 4'b1111; tick(); mask_we = 1'b0;
    check_outs("sw done", 1'b0, 2'd3, 4'b0000, 1'b0);

    // reset while in SERVICE with irq_in[1] held high
    irq_in = 4'b0010; tick(); tick(); tick(); tick();
    check_outs("rm req", 1'b1, 2'd1, 4'b0010, 1'b0);
    ack = 1'b1; tick(); ack = 1'b0;
    check("rm svc", 32'(in_service), 32'd1);
    rst = 1'b1; tick();
    check_outs("rm rst", 1'b0, 2'd0, 4'b0000, 1'b0);
    tick(); rst = 1'b0;
    tick(); tick(); tick();
    check("rm edge3 req", 32'(irq_req), 32'd0);
    tick();
    check_outs("rm post", 1'b1, 2'd1, 4'b0010, 1'b0);
    ack = 1'b1; tick(); ack = 1'b0;
    eret = 1'b1; tick(); eret = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("rm held req", 32'(irq_req), 32'd0);
      check("rm held pend", 32'(pending), 32'h0);
    end
    irq_in = '0; tick(); tick();

`ifdef IRQ_CTRL_DEBUG_EN
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    serve(0, 1'b1);
    serve(1, 1'b0);
    serve(2, 1'b0);
    debug_addr = 7'd3; #1; check("dbg acks", debug_data, 32'd3);
    debug_addr = 7'd4; #1; check("dbg lost", debug_data, 32'd1);
    debug_addr = 7'd9; #1; check("dbg unmapped", debug_data, 32'd0);
    debug_addr = 7'd1; #1; check("dbg mask", debug_data, 32'hf);
    debug_addr = 7'd2; #1; check("dbg status", debug_data, 32'h2);
    debug_addr = 7'd0; #1; check("dbg pending", debug_data, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Parametrised multi-channel interrupt controller between external interrupt sources and the mips core.
- Generalises the single `interrupter` line to N_CH channels, each with a synchroniser, rising-edge capture, a pending latch and a mask bit.
- Fixed priority: lowest channel index wins.
- Presents one request plus channel ID to the core, with an ack/eret handshake and service tracking.

Parameters:
- N_CH, 4, number of interrupt channels (1..32)
- SYNC_STAGES, 2, synchroniser flops per channel (>=1)
- ID_W, 2, width of irq_id; must satisfy 2**ID_W >= N_CH
- MASK_RST, all-ones, reset value of the mask register (1 = enabled)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- irq_in  in  N_CH  raw interrupt lines, may be asynchronous
- mask_we  in  1  write strobe for the mask register
- mask_wdata  in  N_CH  new mask value
- ack  in  1  core accepts the presented request
- eret  in  1  core finished the handler
- irq_req  out  1  request to the core
- irq_id  out  ID_W  channel being requested or serviced
- pending  out  N_CH  pending latches, masked or not
- in_service  out  1  handler active

Behaviour:
- Reset: on a clk edge with rst=1, all of the following clear to 0:
  - synchroniser flops, edge flops, pending, irq_req, irq_id, in_service
  - state returns to IDLE; mask loads MASK_RST
  - Reset mid-handshake abandons the service; no ack/eret is required afterwards.
  - An irq_in held high across reset release registers as one rising edge.
- Edge capture:
  - edge[i] = sync_out[i] & ~sync_prev[i].
  - edge[i] sets pending[i] on the next clk edge.
  - Level-held inputs produce exactly one event.
  - Minimum detectable pulse is 1 clk.
  - Further edges on an already-pending channel are lost (no counting).
- Mask:
  - mask_we writes the mask at the clk edge; the new mask affects selection from the next cycle.
  - Masked channels still latch pending but are never selected.
- Selection: sel = lowest i with pending[i] & mask[i]; valid if any such i exists.
- FSM:
  - IDLE: if valid, next = REQ; irq_id <= sel; irq_req <= 1.
  - REQ:
    - irq_id and irq_req are frozen, even if a higher-priority channel becomes pending.
    - On ack: pending[irq_id] clears, irq_req <= 0, in_service <= 1, next = SERVICE.
  - SERVICE:
    - No new request is issued.
    - On eret: in_service <= 0, next = IDLE.
    - irq_id holds its value until it is reloaded.
  - ack outside REQ is ignored; eret outside SERVICE is ignored.
- Simultaneous events:
  - A new edge on channel k in the same cycle that ack clears pending[k]: pending[k] stays 1 (set wins).
  - Masking the requested channel while in REQ does not withdraw the request.
  - mask_we together with a state transition: the transition uses the old mask.
- Latency: first clk edge sampling irq_in high = edge 1; pending sets at edge SYNC_STAGES+1; irq_req high after edge SYNC_STAGES+2 (default: 4 edges). Back-to-back interrupts: eret at edge e gives IDLE after e; the next irq_req is high after e+1.

Optional Feature:
- Macro: IRQ_CTRL_DEBUG_EN
- Defined:
  - Adds ports debug_addr (in, 7) and debug_data (out, 32), combinational read.
  - Address map:
    - 0: pending, zero-extended
    - 1: mask
    - 2: {state, in_service, irq_id}
    - 3: 32-bit count of accepted acks, wrapping at 2^32 and reset by rst
    - 4: 32-bit count of lost edges (edge on an already-pending channel)
    - other addresses read 0
- Undefined: ports, counters and read mux are absent; all other behaviour is identical.

Decomposition:
- Package irq_ctrl_pkg: FSM state encoding (IDLE=2'd0, REQ=2'd1, SERVICE=2'd2), debug address constants, default parameter values.
- Sub-module irq_sync_edge: one-channel synchroniser plus edge detector, parameterised by SYNC_STAGES. Instantiated N_CH times via generate.

Test Plan:
- Reset/latency: rst for 5 clk, irq_in[0] pulse 2 clk → irq_req=1 after the 4th edge, irq_id=0, pending=4'b0001; ack → pending=0, in_service=1; eret → in_service=0, irq_req stays 0.
- Priority/freeze: irq_in[2], then irq_in[1] 1 clk later, before ack → irq_id=2 (frozen); after ack and eret → irq_req=1, irq_id=1 on the next valid cycle.
- Mask: write mask=4'b1110, pulse irq_in[0] → pending[0]=1, irq_req stays 0 for 20 clk; write mask=4'b1111 → irq_req=1, irq_id=0 two edges later.
- Set-wins: in REQ for channel 3, a new irq_in[3] edge arrives in the same cycle as ack → pending[3]=1 after ack; after eret, channel 3 is requested again.
- Reset mid-operation: assert rst while in SERVICE with irq_in[1] held high → all outputs 0; after release, one request for id=1, and none repeated while the line is held.
- Debug (IRQ_CTRL_DEBUG_EN): 3 complete ack/eret cycles plus one lost edge → debug_addr=3 reads 32'd3, debug_addr=4 reads 32'd1, debug_addr=9 reads 0.
